// File: rtl/z_writeback_unit_pkg.sv
// Shared CPU definitions: opcodes and writeback FSM state encoding.
// Opcode values are common to the ALU, control unit and writeback unit.
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_LOADI  = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b00010;
    localparam logic [4:0] OP_ADDI   = 5'b01100;
    localparam logic [4:0] OP_MUL    = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_BRANCH = 5'b10010;
    localparam logic [4:0] OP_MFHI   = 5'b10111;
    localparam logic [4:0] OP_MFLO   = 5'b11000;
    localparam logic [4:0] OP_NOP    = 5'b11001;
    localparam logic [4:0] OP_HALT   = 5'b11010;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRV_LO = 2'd1;
    localparam logic [1:0] S_DRV_HI = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_nowrite(input logic [4:0] op);
        return (op == OP_BRANCH) || (op == OP_NOP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/z_writeback_unit_reg32_en.sv
// Word register with load enable and synchronous active-high clear.
// Used for ZHI/ZLO staging and the architectural HI/LO registers.
module reg32_en #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load.
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/z_writeback_unit.sv
// Z writeback: stages the 64-bit ALU result and sequences it onto the
// 32-bit bus one word per granted cycle; owns HI/LO.
module z_writeback_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [2*WIDTH-1:0] c_in,
    input  logic               bus_grant,
    output logic [WIDTH-1:0]   bus_out,
    output logic               bus_req,
    output logic               wr_rz,
    output logic               wr_lo,
    output logic               wr_hi,
    output logic               wr_mar,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi_q,
    output logic [WIDTH-1:0]   lo_q
);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] zhi;
    logic [WIDTH-1:0] zlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             cap;
    logic             gnt;
    logic             lo_en;
    logic             hi_en;

    // A clear cycle never issues a write, even with grant high.
    assign cap   = start && (state == S_IDLE);
    assign gnt   = bus_grant && !clr;
    assign lo_en = (state == S_DRV_LO) && gnt && is_muldiv(op_q);
    assign hi_en = (state == S_DRV_HI) && gnt;

    reg32_en #(.W(WIDTH)) u_zhi (
        .clk(clk), .clr(clr), .en(cap),
        .d(c_in[2*WIDTH-1:WIDTH]), .q(zhi)
    );

    reg32_en #(.W(WIDTH)) u_zlo (
        .clk(clk), .clr(clr), .en(cap),
        .d(c_in[WIDTH-1:0]), .q(zlo)
    );

    reg32_en #(.W(WIDTH)) u_hi (
        .clk(clk), .clr(clr), .en(hi_en),
        .d(zhi), .q(hi)
    );

    reg32_en #(.W(WIDTH)) u_lo (
        .clk(clk), .clr(clr), .en(lo_en),
        .d(zlo), .q(lo)
    );

    assign hi_q = hi;
    assign lo_q = lo;

    // Opcode of the staged result, captured only from IDLE.
    always_ff @(posedge clk) begin
        if (clr)
            op_q <= '0;
        else if (cap)
            op_q <= opcode;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next state: advance only on grant, no timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = is_nowrite(opcode) ? S_DONE : S_DRV_LO;
            end
            S_DRV_LO: begin
                if (gnt)
                    state_nx = is_muldiv(op_q) ? S_DRV_HI : S_DONE;
            end
            S_DRV_HI: begin
                if (gnt)
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus word, strobes and status; bus_out is zero without a strobe.
    always_comb begin
        bus_out = '0;
        wr_rz   = 1'b0;
        wr_lo   = 1'b0;
        wr_hi   = 1'b0;
        wr_mar  = 1'b0;
        bus_req = (state == S_DRV_LO) || (state == S_DRV_HI);
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        if (state == S_DRV_LO && gnt) begin
            if (op_q == OP_MFHI)
                bus_out = hi;
            else if (op_q == OP_MFLO)
                bus_out = lo;
            else
                bus_out = zlo;
            if (is_muldiv(op_q))
                wr_lo = 1'b1;
            else if (is_mem(op_q))
                wr_mar = 1'b1;
            else
                wr_rz = 1'b1;
        end else if (state == S_DRV_HI && gnt) begin
            bus_out = zhi;
            wr_hi   = 1'b1;
        end
    end

endmodule
